execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipeline, directly upstream of the memory-access stage. It registers one ALU result per accepted instruction and forwards store data, the 3-bit control bundle and the destination register to the memory-access stage. Multiply and divide/remainder run on an iterative unit that stalls the front of the pipe. While that unit is busy, the stage emits bubbles that perform no memory access and no register write.

## Interface
- BW, 32, datapath width; must be a power of two ≥ 8
- SHW, $clog2(BW), shift-amount width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  an instruction is presented this cycle
- in_ready  out  1  stage accepts an instruction this cycle; an instruction is accepted when in_valid && in_ready
- op  in  4  operation code (ex_pkg::ex_op_t)
- src_a  in  BW  operand A (rs1 value)
- src_b  in  BW  operand B (rs2 value)
- imm  in  BW  sign-extended immediate
- use_imm  in  1  1: ALU operand B = imm; store data stays src_b
- con_in  in  3  {MemWrite, MemtoReg, RegWrite}
- rd_in  in  5  destination register
- out_valid  out  1  outputs below carry a real instruction
- alu_out  out  BW  result; the memory-access stage takes the low OW bits as its address
- WriteData  out  BW  store data (src_b captured at accept)
- con_out  out  3  registered con_in; 3'b000 on a bubble
- rd_out  out  5  registered rd_in; 5'd0 on a bubble

## Operation
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT (signed), SLTU.
- Shift ops use only operand B[SHW-1:0].
- ADD and SUB wrap modulo 2^BW with no overflow flag.
- SLT and SLTU produce {BW-1 zeros, bit}.
- Multi-cycle ops: MUL (low BW bits), MULHU (high BW bits, unsigned), DIVU, REMU (unsigned).
  - The MUL/MULHU product is 2·BW bits internally.
- Divide by zero: DIVU returns all ones; REMU returns the dividend. There is no trap.
- Unknown op codes: result 0, con_out forced to 3'b000, out_valid still 1.
- FSM in the muldiv unit: IDLE → RUN (on accepting a multi-cycle op) → DONE (after BW iterations) → IDLE.
  - MUL uses shift-add, one bit per cycle.
  - DIV uses restoring division, one bit per cycle.
- in_ready = 1 in IDLE and DONE; 0 in RUN.
- A bubble is out_valid = 0, con_out = 0, rd_out = 0, with alu_out and WriteData held.
- Bubbles are emitted every cycle that no instruction completes.
- Reset values: all outputs 0, in_ready = 1, FSM IDLE.
- rst asserted during RUN aborts the operation. The next edge shows reset values and no result is emitted.
- in_valid is ignored when in_ready = 0. The upstream stage holds its instruction; this stage does not buffer it.

## Timing
- Single-cycle op accepted at edge N: outputs valid after edge N+1, for exactly one cycle unless another instruction follows.
- Multi-cycle op accepted at edge N:
  - in_ready low for cycles N+1 … N+BW.
  - Result registered at edge N+BW+1 with out_valid = 1, latency BW+1.
  - in_ready is high during that DONE cycle, so a new instruction can be accepted at the same edge the result appears.
- Back-to-back single-cycle ops sustain one result per cycle.
- con, rd and WriteData travel with their instruction. During RUN they are held in the muldiv unit, not re-sampled.

## Configuration
- EX_MULDIV_EN defined: the muldiv unit is instantiated and behaves as described above.
- EX_MULDIV_EN undefined:
  - No muldiv unit is instantiated.
  - MUL/MULHU/DIVU/REMU are treated as unknown op codes (result 0, con 000, one cycle).
  - in_ready is tied to 1.

## Structure
- Package ex_pkg holds:
  - ex_op_t enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULHU=11, DIVU=12, REMU=13.
  - Constants CON_MEMWRITE=2, CON_MEMTOREG=1, CON_REGWRITE=0.
  - The muldiv FSM state enum.
- One sub-module: ex_muldiv (iterative multiply/divide with FSM, handshake start/busy/done).

## Test plan
- Reset: rst high 2 cycles → all outputs 0, in_ready = 1; after release with in_valid = 0 → bubbles only.
- ADD, src_a = 32'h7FFFFFFF, imm = 1, use_imm = 1, con_in = 3'b011, rd_in = 5'b11011 → next cycle alu_out = 32'h80000000, con_out = 011, rd_out = 27, out_valid = 1.
- Store, ADD, src_a = 4, imm = 0, src_b = 32'h77777777, con_in = 3'b100 → alu_out = 4, WriteData = 32'h77777777, con_out = 100.
- MUL, 32'h0001_0001 × 32'h0000_FFFF → in_ready low 32 cycles, bubbles throughout; at cycle 33 alu_out = 32'hFFFF_FFFF; MULHU of the same operands → 32'h0000_0000.
- DIVU, 100 / 7 → 14; REMU → 2; DIVU, x / 0 with x = 32'h12345678 → 32'hFFFFFFFF; REMU → 32'h12345678.
- rst asserted at cycle 10 of a DIVU → no result ever appears with out_valid = 1, in_ready = 1 the cycle after reset; SRA 32'h80000000 by 31 then gives 32'hFFFFFFFF.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared types for the execute stage.
// Op-code enum, control-bundle bit positions, muldiv FSM states and
// small op-classification helpers.
package ex_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SLL   = 4'd5,
        SRL   = 4'd6,
        SRA   = 4'd7,
        SLT   = 4'd8,
        SLTU  = 4'd9,
        MUL   = 4'd10,
        MULHU = 4'd11,
        DIVU  = 4'd12,
        REMU  = 4'd13
    } ex_op_t;

    // Bit positions inside the 3-bit control bundle {MemWrite, MemtoReg, RegWrite}.
    localparam int CON_MEMWRITE = 2;
    localparam int CON_MEMTOREG = 1;
    localparam int CON_REGWRITE = 0;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // Ops that complete in the single-cycle ALU.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= 4'(SLTU);
    endfunction

    // Ops handled by the iterative multiply/divide unit.
    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == 4'(MUL)) || (op == 4'(MULHU)) ||
               (op == 4'(DIVU)) || (op == 4'(REMU));
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative unsigned multiply (shift-add) and restoring divide,
// one bit per cycle. A single 2*BW accumulator serves both:
//   multiply: {product_hi, product_lo}, multiplier consumed from bit 0
//   divide:   {remainder, quotient}, dividend shifted out of the top of lo
// done is asserted combinationally during the last RUN cycle and result is
// the value the accumulator takes at that edge, so the caller can register
// the result on the same edge the FSM enters DONE.
// Divide by zero falls out of the restoring algorithm naturally:
// every step "subtracts" 0, giving an all-ones quotient and remainder = dividend.
module ex_muldiv
    import ex_pkg::*;
#(
    parameter int BW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [BW-1:0]   src_a,
    input  logic [BW-1:0]   src_b,
    input  logic [BW-1:0]   wdata_in,
    input  logic [2:0]      con_in,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [BW-1:0]   result,
    output logic [BW-1:0]   wdata_out,
    output logic [2:0]      con_out,
    output logic [4:0]      rd_out,
    output md_state_t       state
);

    localparam int CW = $clog2(BW);

    logic [CW-1:0]   cnt;
    logic [2*BW-1:0] acc;
    logic [2*BW-1:0] acc_nxt;
    logic [BW-1:0]   opnd;
    logic [3:0]      op_q;
    logic [BW:0]     mul_sum;
    logic [BW:0]     div_sh;
    logic [BW-1:0]   div_diff;
    logic            div_ge;
    logic            run_mul;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        run_mul  = (op_q == 4'(MUL)) || (op_q == 4'(MULHU));
        mul_sum  = {1'b0, acc[2*BW-1:BW]} + (acc[0] ? {1'b0, opnd} : {(BW+1){1'b0}});
        div_sh   = {acc[2*BW-1:BW], acc[BW-1]};
        div_ge   = div_sh >= {1'b0, opnd};
        div_diff = div_sh[BW-1:0] - opnd;
        if (run_mul) begin
            acc_nxt = {mul_sum, acc[BW-1:1]};
        end else begin
            acc_nxt = {(div_ge ? div_diff : div_sh[BW-1:0]), acc[BW-2:0], div_ge};
        end
    end

    // Handshake and result selection.
    always_comb begin
        busy   = (state == MD_RUN);
        done   = (state == MD_RUN) && (cnt == CW'(BW-1));
        result = ((op_q == 4'(MUL)) || (op_q == 4'(DIVU))) ? acc_nxt[BW-1:0]
                                                          : acc_nxt[2*BW-1:BW];
    end

    // FSM: IDLE/DONE accept a start, RUN iterates BW times then enters DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MD_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            op_q      <= '0;
            wdata_out <= '0;
            con_out   <= '0;
            rd_out    <= '0;
        end else begin
            case (state)
                MD_RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (done) begin
                        state <= MD_DONE;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= MD_RUN;
                        cnt       <= '0;
                        op_q      <= op;
                        wdata_out <= wdata_in;
                        con_out   <= con_in;
                        rd_out    <= rd_in;
                        if ((op == 4'(MUL)) || (op == 4'(MULHU))) begin
                            acc  <= {{BW{1'b0}}, src_b};
                            opnd <= src_a;
                        end else begin
                            acc  <= {{BW{1'b0}}, src_a};
                            opnd <= src_b;
                        end
                    end else begin
                        state <= MD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: registers one ALU result per accepted instruction and
// forwards store data, control bundle and rd to the memory-access stage.
// Macro EX_MULDIV_EN: when defined, MUL/MULHU/DIVU/REMU run on ex_muldiv and
// stall the front of the pipe; when undefined they are unknown ops and
// in_ready is tied high.
// Handshake: an instruction is taken on a rising edge where in_valid && in_ready;
// out_valid marks the one cycle in which the outputs carry a real instruction,
// otherwise the stage shows a bubble (con_out = 0, rd_out = 0, data held).
module execute_stage
    import ex_pkg::*;
#(
    parameter int BW  = 32,
    parameter int SHW = $clog2(BW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [BW-1:0]   src_a,
    input  logic [BW-1:0]   src_b,
    input  logic [BW-1:0]   imm,
    input  logic            use_imm,
    input  logic [2:0]      con_in,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    output logic [BW-1:0]   alu_out,
    output logic [BW-1:0]   WriteData,
    output logic [2:0]      con_out,
    output logic [4:0]      rd_out
);

    logic [BW-1:0]  op_b;
    logic [SHW-1:0] shamt;
    logic [BW-1:0]  alu_res;
    logic           accept;
    logic           md_op;
    logic           md_done;
    logic [BW-1:0]  md_result;
    logic [BW-1:0]  md_wdata;
    logic [2:0]     md_con;
    logic [4:0]     md_rd;

    // Single-cycle ALU; anything not recognised yields 0.
    always_comb begin
        op_b    = use_imm ? imm : src_b;
        shamt   = op_b[SHW-1:0];
        alu_res = '0;
        case (op)
            4'(ADD):  alu_res = src_a + op_b;
            4'(SUB):  alu_res = src_a - op_b;
            4'(AND):  alu_res = src_a & op_b;
            4'(OR):   alu_res = src_a | op_b;
            4'(XOR):  alu_res = src_a ^ op_b;
            4'(SLL):  alu_res = src_a << shamt;
            4'(SRL):  alu_res = src_a >> shamt;
            4'(SRA):  alu_res = $signed(src_a) >>> shamt;
            4'(SLT):  alu_res = {{(BW-1){1'b0}}, $signed(src_a) < $signed(op_b)};
            4'(SLTU): alu_res = {{(BW-1){1'b0}}, src_a < op_b};
            default:  alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    logic      md_busy;
    md_state_t md_state;

    assign md_op    = is_muldiv_op(op);
    assign in_ready = ~md_busy;

    ex_muldiv #(.BW(BW)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (accept && md_op),
        .op        (op),
        .src_a     (src_a),
        .src_b     (op_b),
        .wdata_in  (src_b),
        .con_in    (con_in),
        .rd_in     (rd_in),
        .busy      (md_busy),
        .done      (md_done),
        .result    (md_result),
        .wdata_out (md_wdata),
        .con_out   (md_con),
        .rd_out    (md_rd),
        .state     (md_state)
    );
`else
    assign md_op     = 1'b0;
    assign in_ready  = 1'b1;
    assign md_done   = 1'b0;
    assign md_result = '0;
    assign md_wdata  = '0;
    assign md_con    = '0;
    assign md_rd     = '0;
`endif

    assign accept = in_valid && in_ready;

    // Output register: muldiv completion, single-cycle result, or bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_out   <= '0;
            WriteData <= '0;
            con_out   <= '0;
            rd_out    <= '0;
        end else if (md_done) begin
            out_valid <= 1'b1;
            alu_out   <= md_result;
            WriteData <= md_wdata;
            con_out   <= md_con;
            rd_out    <= md_rd;
        end else if (accept && !md_op) begin
            out_valid <= 1'b1;
            alu_out   <= alu_res;
            WriteData <= src_b;
            con_out   <= is_alu_op(op) ? con_in : 3'b000;
            rd_out    <= rd_in;
        end else begin
            out_valid <= 1'b0;
            con_out   <= '0;
            rd_out    <= '0;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: random and directed stimulus for execute_stage with a
// queue-based scoreboard. Expected results come from plain arithmetic on the
// operands; expected timing comes from the accept cycle plus the op latency.
module tb_execute_stage;
  import ex_pkg::*;

  localparam int BW  = 32;
  localparam int SHW = 5;
`ifdef EX_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [BW-1:0] src_a;
  logic [BW-1:0] src_b;
  logic [BW-1:0] imm;
  logic          use_imm;
  logic [2:0]    con_in;
  logic [4:0]    rd_in;
  logic          out_valid;
  logic [BW-1:0] alu_out;
  logic [BW-1:0] WriteData;
  logic [2:0]    con_out;
  logic [4:0]    rd_out;

  typedef struct packed {
    logic [31:0]   due;
    logic [BW-1:0] alu;
    logic [BW-1:0] wd;
    logic [2:0]    con;
    logic [4:0]    rd;
  } exp_t;

  exp_t          exp_q[$];
  int            total;
  int            bad;
  int            cyc;
  int            busy_lo;
  int            busy_hi;
  logic [BW-1:0] last_alu;
  logic [BW-1:0] last_wd;

  execute_stage #(.BW(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .imm       (imm),
    .use_imm   (use_imm),
    .con_in    (con_in),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .alu_out   (alu_out),
    .WriteData (WriteData),
    .con_out   (con_out),
    .rd_out    (rd_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // reference model
  // 0 = unknown op, 1 = single-cycle, 2 = multi-cycle
  function automatic int op_kind(input logic [3:0] o);
    if (o <= 4'd9) return 1;
    if (o <= 4'd13) return MD_EN ? 2 : 0;
    return 0;
  endfunction

  function automatic logic [BW-1:0] ref_val(input logic [3:0] o, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    logic [2*BW-1:0] p;
    int              sh;
    p  = {{BW{1'b0}}, a} * {{BW{1'b0}}, b};
    sh = int'(b % BW);
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[BW-1] ? ~({BW{1'b1}} >> sh) : {BW{1'b0}});
      4'd8:  return ($signed(a) < $signed(b)) ? BW'(1) : BW'(0);
      4'd9:  return (a < b) ? BW'(1) : BW'(0);
      4'd10: return p[BW-1:0];
      4'd11: return p[2*BW-1:BW];
      4'd12: return (b == 0) ? {BW{1'b1}} : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic send(input logic [3:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b,
                      input logic [BW-1:0] im, input logic ui, input logic [2:0] c,
                      input logic [4:0] r);
    int            guard;
    int            k;
    exp_t          e;
    logic [BW-1:0] ob;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    imm      = im;
    use_imm  = ui;
    con_in   = c;
    rd_in    = r;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", 64'(guard < 200), 64'(1));
    if (guard >= 200) begin
      in_valid = 1'b0;
      return;
    end
    ob    = ui ? im : b;
    k     = op_kind(o);
    e.due = 32'(cyc + ((k == 2) ? BW + 1 : 1));
    e.alu = (k == 0) ? '0 : ref_val(o, a, ob);
    e.wd  = b;
    e.con = (k == 0) ? 3'b000 : c;
    e.rd  = r;
    if (k == 2) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + BW;
    end
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      op       = 4'($urandom_range(0, 15));
      src_a    = $urandom;
      src_b    = $urandom;
      imm      = $urandom;
      use_imm  = 1'($urandom_range(0, 1));
      con_in   = 3'($urandom_range(0, 7));
      rd_in    = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor, sampling 1 time unit after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (rst) begin
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_alu", 64'(alu_out), 64'(0));
      chk("rst_wd", 64'(WriteData), 64'(0));
      chk("rst_con_rd", 64'({con_out, rd_out}), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(1));
      exp_q.delete();
      busy_lo  = 1;
      busy_hi  = 0;
      last_alu = '0;
      last_wd  = '0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(cyc >= busy_lo && cyc <= busy_hi)));
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("latency", 64'(cyc), 64'(e.due));
          chk("alu_out", 64'(alu_out), 64'(e.alu));
          chk("WriteData", 64'(WriteData), 64'(e.wd));
          chk("con_out", 64'(con_out), 64'(e.con));
          chk("rd_out", 64'(rd_out), 64'(e.rd));
          last_alu = e.alu;
          last_wd  = e.wd;
        end
      end else begin
        chk("bubble_con_rd", 64'({out_valid, con_out, rd_out}), 64'(0));
        chk("bubble_hold", {alu_out, WriteData}, {last_alu, last_wd});
        if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
          chk("missing_out", 64'(cyc), 64'(exp_q[0].due));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0]    o;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    total    = 0;
    bad      = 0;
    cyc      = 0;
    busy_lo  = 1;
    busy_hi  = 0;
    last_alu = '0;
    last_wd  = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    op       = '0;
    src_a    = '0;
    src_b    = '0;
    imm      = '0;
    use_imm  = 1'b0;
    con_in   = '0;
    rd_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // directed cases
    send(ADD, 32'h7FFFFFFF, 32'h0, 32'd1, 1'b1, 3'b011, 5'd27);
    send(ADD, 32'd4, 32'h77777777, 32'd0, 1'b1, 3'b100, 5'd0);
    idle(2);
    send(MUL, 32'h00010001, 32'h0000FFFF, 32'd0, 1'b0, 3'b001, 5'd5);
    send(MULHU, 32'h00010001, 32'h0000FFFF, 32'd0, 1'b0, 3'b001, 5'd6);
    send(DIVU, 32'd100, 32'd7, 32'd0, 1'b0, 3'b001, 5'd7);
    send(REMU, 32'd100, 32'd7, 32'd0, 1'b0, 3'b001, 5'd8);
    send(DIVU, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'b001, 5'd9);
    send(REMU, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'b001, 5'd10);
    send(4'd14, 32'd3, 32'd4, 32'd0, 1'b0, 3'b111, 5'd11);
    send(4'd15, 32'd3, 32'd4, 32'd0, 1'b0, 3'b111, 5'd12);
    send(SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'b001, 5'd13);
    send(SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'b001, 5'd14);
    send(SUB, 32'd0, 32'd1, 32'd0, 1'b0, 3'b001, 5'd15);
    idle(3);

    // reset in the middle of a divide, then a shift
    send(DIVU, 32'hDEADBEEF, 32'd3, 32'd0, 1'b0, 3'b001, 5'd16);
    idle(9);
    reset_pulse(1);
    send(SRA, 32'h80000000, 32'd0, 32'd31, 1'b1, 3'b001, 5'd3);
    idle(3);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? BW'($urandom_range(0, 40)) : BW'($urandom);
      if ($urandom_range(0, 15) == 0) b = '0;
      send(o, a, b, $urandom_range(0, 3) == 0 ? BW'($urandom_range(0, 63)) : BW'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    idle(BW + 5);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
